// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with wait-state timeout and sticky trap.
// Optional retired-instruction counter enabled by defining CTRL_PERF_EN.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  instr_opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        branch,
  output logic        jump,
  output logic        trap,
  output logic        bus_error,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [2:0]      state_q, state_d, fsm_next;
  logic [6:0]      op_q;
  logic [TO_W-1:0] wait_q;
  logic            trap_q, bus_error_q;
  logic            waiting, timeout_hit;

  logic c_mem_req, c_mem_we, c_iord, c_ir_write, c_pc_write, c_alu_src;
  logic c_mem_to_reg, c_reg_write, c_branch, c_jump;
  logic [1:0] c_alu_op;

  logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, legal;
  assign is_r     = (op_q == OP_R);
  assign is_i     = (op_q == OP_I);
  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);
  assign is_br    = (op_q == OP_BR);
  assign is_jal   = (op_q == OP_JAL);
  assign is_jalr  = (op_q == OP_JALR);
  assign is_lui   = (op_q == OP_LUI);
  assign is_auipc = (op_q == OP_AUIPC);
  assign legal    = is_r | is_i | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc;

  always_comb begin
    fsm_next     = state_q;
    c_mem_req    = 1'b0;
    c_mem_we     = 1'b0;
    c_iord       = 1'b0;
    c_ir_write   = 1'b0;
    c_pc_write   = 1'b0;
    c_alu_src    = 1'b0;
    c_alu_op     = 2'b00;
    c_mem_to_reg = 1'b0;
    c_reg_write  = 1'b0;
    c_branch     = 1'b0;
    c_jump       = 1'b0;
    case (state_q)
      S_FETCH: begin
        c_mem_req = run;
        if (run && mem_ready) begin
          c_ir_write = 1'b1;
          c_pc_write = 1'b1;
          fsm_next   = S_DEC;
        end
      end
      S_DEC: fsm_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_r) begin
          c_alu_op = 2'b10;
          fsm_next = S_WB;
        end else if (is_i || is_auipc) begin
          c_alu_src = 1'b1;
          fsm_next  = S_WB;
        end else if (is_lui) begin
          c_alu_src = 1'b1;
          c_alu_op  = 2'b11;
          fsm_next  = S_WB;
        end else if (is_load) begin
          c_alu_src = 1'b1;
          c_alu_op  = 2'b11;
          fsm_next  = S_MEM;
        end else if (is_store) begin
          c_alu_src = 1'b1;
          fsm_next  = S_MEM;
        end else if (is_br) begin
          c_alu_op = 2'b01;
          c_branch = 1'b1;
          fsm_next = S_FETCH;
        end else if (is_jal || is_jalr) begin
          c_alu_src   = is_jalr;
          c_jump      = 1'b1;
          c_reg_write = 1'b1;
          fsm_next    = S_FETCH;
        end else begin
          fsm_next = S_TRAP;
        end
      end
      S_MEM: begin
        c_mem_req = 1'b1;
        c_iord    = 1'b1;
        c_alu_src = 1'b1;
        c_mem_we  = is_store;
        if (mem_ready) fsm_next = is_store ? S_FETCH : S_WB;
      end
      S_WB: begin
        c_reg_write  = 1'b1;
        c_mem_to_reg = is_load;
        fsm_next     = S_FETCH;
      end
      S_TRAP:  fsm_next = S_TRAP;
      default: fsm_next = S_TRAP;
    endcase
  end

  // A completing request in the timeout cycle takes priority over the bus error.
  assign waiting     = c_mem_req & ~mem_ready;
  assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && (wait_q == TO_W'(MEM_TIMEOUT));
  assign state_d     = timeout_hit ? S_TRAP : fsm_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      op_q        <= 7'd0;
      wait_q      <= '0;
      trap_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (c_ir_write) op_q <= instr_opcode;
      if ((state_d != state_q) || (state_q == S_FETCH && !run)) wait_q <= '0;
      else if (waiting && wait_q != '1) wait_q <= wait_q + 1'b1;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (timeout_hit) bus_error_q <= 1'b1;
    end
  end

  assign mem_req    = c_mem_req & ~rst;
  assign mem_we     = c_mem_we & ~rst;
  assign iord       = c_iord & ~rst;
  assign ir_write   = c_ir_write & ~rst;
  assign pc_write   = c_pc_write & ~rst;
  assign alu_src    = c_alu_src & ~rst;
  assign alu_op     = rst ? 2'b00 : c_alu_op;
  assign mem_to_reg = c_mem_to_reg & ~rst;
  assign reg_write  = c_reg_write & ~rst;
  assign branch     = c_branch & ~rst;
  assign jump       = c_jump & ~rst;
  assign trap       = trap_q & ~rst;
  assign bus_error  = bus_error_q & ~rst;
  assign state      = rst ? S_FETCH : state_q;

`ifdef CTRL_PERF_EN
  logic        retire;
  logic [31:0] instret_q;
  // An instruction retires when any working state hands control back to FETCH.
  assign retire = (state_q != S_FETCH) && (state_q != S_TRAP) && (state_d == S_FETCH);
  always_ff @(posedge clk) begin
    if (rst) instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
  assign instret = rst ? 32'd0 : instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction classes, wait states, traps, timeout.
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        rst, run, mem_ready;
  logic [6:0]  instr_opcode;
  logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg, reg_write, branch, jump, trap, bus_error;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [11:0] ctl;

  int vectors = 0;
  int miscompares = 0;

`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // ctl = {mem_req, mem_we, iord, ir_write, pc_write, alu_src, alu_op, mem_to_reg, reg_write, branch, jump}
  localparam logic [11:0] C_FETCH_RDY  = 12'b100110000000;
  localparam logic [11:0] C_FETCH_WAIT = 12'b100000000000;
  localparam logic [11:0] C_NONE       = 12'b000000000000;
  localparam logic [11:0] C_EX_R       = 12'b000000100000;
  localparam logic [11:0] C_EX_IMM     = 12'b000001000000;
  localparam logic [11:0] C_EX_LDLUI   = 12'b000001110000;
  localparam logic [11:0] C_EX_BR      = 12'b000000010010;
  localparam logic [11:0] C_EX_JAL     = 12'b000000000101;
  localparam logic [11:0] C_EX_JALR    = 12'b000001000101;
  localparam logic [11:0] C_MEM_LD     = 12'b101001000000;
  localparam logic [11:0] C_MEM_ST     = 12'b111001000000;
  localparam logic [11:0] C_WB         = 12'b000000000100;
  localparam logic [11:0] C_WB_LD      = 12'b000000001100;

  assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, alu_src, alu_op,
                mem_to_reg, reg_write, branch, jump};

  multicycle_control_unit #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_opcode(instr_opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .branch(branch), .jump(jump), .trap(trap), .bus_error(bus_error), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    run = 1'b1; mem_ready = 1'b1; instr_opcode = OP_R;
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || ctl !== C_NONE || trap !== 1'b0 || bus_error !== 1'b0 || instret !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got state=%0d ctl=%b trap=%b berr=%b instret=%0d want all zero",
               state, ctl, trap, bus_error, instret);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_r_type;
    logic [2:0]  es[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [11:0] ec[5] = '{C_FETCH_RDY, C_NONE, C_EX_R, C_WB, C_FETCH_RDY};
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_opcode = OP_R;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        miscompares++;
        $display("FAIL r_type_cyc%0d got state=%0d ctl=%b want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
      end
      if (i < 4) tick();
    end
    vectors++;
    if (instret !== (PERF ? 32'd1 : 32'd0)) begin
      miscompares++;
      $display("FAIL r_type_instret got %0d want %0d", instret, PERF ? 1 : 0);
    end
  endtask

  task automatic test_load_wait;
    logic        rdy[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  es[9]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic [11:0] ec[9]  = '{C_FETCH_RDY, C_NONE, C_EX_LDLUI, C_MEM_LD, C_MEM_LD, C_MEM_LD,
                            C_MEM_LD, C_WB_LD, C_FETCH_RDY};
    do_reset();
    run = 1'b1; instr_opcode = OP_LOAD;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        miscompares++;
        $display("FAIL load_wait_cyc%0d got state=%0d ctl=%b want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
      end
      if (i < 8) tick();
    end
    vectors++;
    if (instret !== (PERF ? 32'd1 : 32'd0)) begin
      miscompares++;
      $display("FAIL load_instret got %0d want %0d", instret, PERF ? 1 : 0);
    end
  endtask

  task automatic test_store;
    logic [2:0]  es[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [11:0] ec[5] = '{C_FETCH_RDY, C_NONE, C_EX_IMM, C_MEM_ST, C_FETCH_RDY};
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_opcode = OP_STORE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (state !== es[i] || ctl !== ec[i]) begin
        miscompares++;
        $display("FAIL store_cyc%0d got state=%0d ctl=%b want state=%0d ctl=%b", i, state, ctl, es[i], ec[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0]  ops[6] = '{OP_BR, OP_JAL, OP_JALR, OP_I, OP_LUI, OP_AUIPC};
    logic [11:0] ex[6]  = '{C_EX_BR, C_EX_JAL, C_EX_JALR, C_EX_IMM, C_EX_LDLUI, C_EX_IMM};
    logic        wb[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr_opcode = ops[k];
      @(negedge clk);
      vectors++;
      if (state !== 3'd0 || ctl !== C_FETCH_RDY || instret !== (PERF ? 32'(k) : 32'd0)) begin
        miscompares++;
        $display("FAIL b2b_fetch%0d got state=%0d ctl=%b instret=%0d want state=0 ctl=%b instret=%0d",
                 k, state, ctl, instret, C_FETCH_RDY, PERF ? k : 0);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (state !== 3'd1 || ctl !== C_NONE) begin
        miscompares++;
        $display("FAIL b2b_decode%0d got state=%0d ctl=%b want state=1 ctl=%b", k, state, ctl, C_NONE);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (state !== 3'd2 || ctl !== ex[k]) begin
        miscompares++;
        $display("FAIL b2b_exec%0d got state=%0d ctl=%b want state=2 ctl=%b", k, state, ctl, ex[k]);
      end
      tick();
      if (wb[k]) begin
        @(negedge clk);
        vectors++;
        if (state !== 3'd4 || ctl !== C_WB) begin
          miscompares++;
          $display("FAIL b2b_wb%0d got state=%0d ctl=%b want state=4 ctl=%b", k, state, ctl, C_WB);
        end
        tick();
      end
    end
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || instret !== (PERF ? 32'd6 : 32'd0)) begin
      miscompares++;
      $display("FAIL b2b_end got state=%0d instret=%0d want state=0 instret=%0d", state, instret, PERF ? 6 : 0);
    end
  endtask

  task automatic test_illegal;
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_opcode = 7'b0000000;
    tick();
    @(negedge clk);
    vectors++;
    if (state !== 3'd1 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_decode got state=%0d trap=%b want state=1 trap=0", state, trap);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      instr_opcode = 7'($urandom_range(0, 127));
      @(negedge clk);
      vectors++;
      if (state !== 3'd5 || trap !== 1'b1 || bus_error !== 1'b0 || ctl !== C_NONE) begin
        miscompares++;
        $display("FAIL illegal_trap%0d got state=%0d trap=%b berr=%b ctl=%b want state=5 trap=1 berr=0 ctl=0",
                 i, state, trap, bus_error, ctl);
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || trap !== 1'b0 || ctl !== C_NONE) begin
      miscompares++;
      $display("FAIL illegal_in_rst got state=%0d trap=%b ctl=%b want 0/0/0", state, trap, ctl);
    end
    tick();
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || trap !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_after_rst got state=%0d trap=%b want state=0 trap=0", state, trap);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    run = 1'b1; mem_ready = 1'b0; instr_opcode = OP_R;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vectors++;
      if (state !== 3'd0 || ctl !== C_FETCH_WAIT) begin
        miscompares++;
        $display("FAIL timeout_wait%0d got state=%0d ctl=%b want state=0 ctl=%b", i, state, ctl, C_FETCH_WAIT);
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (state !== 3'd5 || trap !== 1'b1 || bus_error !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_trap got state=%0d trap=%b berr=%b want state=5 trap=1 berr=1", state, trap, bus_error);
    end
  endtask

  task automatic test_timeout_rescue;
    do_reset();
    run = 1'b1; mem_ready = 1'b0; instr_opcode = OP_R;
    for (int i = 0; i < 10; i++) tick();
    run = 1'b0;
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || ctl !== C_NONE) begin
      miscompares++;
      $display("FAIL rescue_idle got state=%0d ctl=%b want state=0 ctl=0", state, ctl);
    end
    tick();
    run = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (state !== 3'd0 || ctl !== C_FETCH_RDY) begin
      miscompares++;
      $display("FAIL rescue_edge got state=%0d ctl=%b want state=0 ctl=%b", state, ctl, C_FETCH_RDY);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (state !== 3'd1 || trap !== 1'b0 || bus_error !== 1'b0) begin
      miscompares++;
      $display("FAIL rescue_no_trap got state=%0d trap=%b berr=%b want state=1 trap=0 berr=0", state, trap, bus_error);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; instr_opcode = 7'd0;
    tick();
    test_reset();
    test_r_type();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_timeout_rescue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
